// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ byte producers share one UART
// transmitter. A granted requester keeps the transmitter for a whole packet
// (until req_last), but for no more than MAX_BURST bytes, and it loses the
// grant as soon as it stops presenting data.
//
// Ports
//   clk           : sole clock, rising edge
//   reset         : asynchronous, active-high reset
//   req_valid     : [NUM_REQ]   requester i presents a byte
//   req_data      : [8*NUM_REQ] requester i's byte on [8i+7:8i]
//   req_last      : [NUM_REQ]   presented byte is the last of its packet
//   req_ready     : [NUM_REQ]   requester i's byte is consumed this cycle
//   tx_start      : one-cycle start pulse to the transmitter
//   tx_data       : [8] byte to the transmitter
//   tx_done_tick  : transmitter end-of-frame pulse
//   grant_valid   : a requester currently holds the transmitter
//   grant_id      : [$clog2(NUM_REQ)] index of the granted requester
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done_tick,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [IDW:0]   NUM_REQ_W   = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID     = IDW'(NUM_REQ - 1);
  localparam logic [7:0]     MAX_BURST_W = 8'(MAX_BURST);

  logic [1:0]           state_r;
  logic [1:0]           state_s;
  logic [IDW-1:0]       rr_ptr_r;
  logic [IDW-1:0]       grant_id_r;
  logic                 grant_valid_r;
  logic [7:0]           burst_cnt_r;
  logic                 last_flag_r;
  logic [7:0]           tx_data_r;
  logic                 tx_start_r;

  logic [2*NUM_REQ-1:0] rot_s;
  logic [IDW-1:0]       pick_s;
  logic [IDW:0]         cand_s;
  logic [IDW-1:0]       sel_s;
  logic [7:0]           sel_byte_s;
  logic                 sel_last_s;
  logic                 sel_valid_s;
  logic                 release_s;
  logic [IDW-1:0]       rr_next_s;

  // Circular first-set search starting at rr_ptr: rotate a doubled copy of
  // req_valid so the search itself only ever looks at constant positions.
  always_comb begin
    rot_s  = {req_valid, req_valid} >> rr_ptr_r;
    pick_s = {IDW{1'b0}};
    cand_s = {(IDW + 1){1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_s = {1'b0, rr_ptr_r} + (IDW + 1)'(k);
      if (cand_s >= NUM_REQ_W) begin
        cand_s = cand_s - NUM_REQ_W;
      end else begin
        cand_s = cand_s;
      end
      // Scanning downward, so the last hit is the lowest circular offset.
      if (rot_s[k]) begin
        pick_s = cand_s[IDW-1:0];
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // Requester mux: the newly picked requester in IDLE, the holder otherwise.
  always_comb begin
    sel_s       = (state_r == ST_IDLE) ? pick_s : grant_id_r;
    sel_byte_s  = 8'h00;
    sel_last_s  = 1'b0;
    sel_valid_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_s == IDW'(i)) begin
        sel_byte_s  = req_data[8*i +: 8];
        sel_last_s  = req_last[i];
        sel_valid_s = req_valid[i];
      end else begin
        sel_byte_s  = sel_byte_s;
        sel_last_s  = sel_last_s;
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Release decision and the rotated pointer used when the grant is dropped.
  always_comb begin
    release_s = last_flag_r | (burst_cnt_r == MAX_BURST_W) | ~sel_valid_s;
    if (grant_id_r == LAST_ID) begin
      rr_next_s = {IDW{1'b0}};
    end else begin
      rr_next_s = grant_id_r + IDW'(1);
    end
  end

  // Next-state logic of the grant FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_valid) begin
          state_s = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          state_s = release_s ? ST_IDLE : ST_SEND;
        end else begin
          state_s = ST_WAIT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers. The byte is captured on the edge that
  // enters SEND, so tx_data is already valid alongside the tx_start pulse;
  // the requester must hold it until req_ready, so it is the consumed byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= {IDW{1'b0}};
      grant_id_r    <= {IDW{1'b0}};
      grant_valid_r <= 1'b0;
      burst_cnt_r   <= 8'd0;
      last_flag_r   <= 1'b0;
      tx_data_r     <= 8'h00;
      tx_start_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      tx_start_r <= (state_s == ST_SEND);
      case (state_r)
        ST_IDLE: begin
          if (|req_valid) begin
            grant_id_r    <= pick_s;
            grant_valid_r <= 1'b1;
            burst_cnt_r   <= 8'd0;
            tx_data_r     <= sel_byte_s;
            last_flag_r   <= sel_last_s;
          end else begin
            grant_valid_r <= 1'b0;
          end
        end
        ST_SEND: begin
          burst_cnt_r <= burst_cnt_r + 8'd1;
        end
        ST_WAIT: begin
          if (tx_done_tick) begin
            if (release_s) begin
              grant_valid_r <= 1'b0;
              rr_ptr_r      <= rr_next_s;
            end else begin
              tx_data_r   <= sel_byte_s;
              last_flag_r <= sel_last_s;
            end
          end else begin
            grant_valid_r <= grant_valid_r;
          end
        end
        default: begin
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // req_ready is a decode of the FSM state, forced low while in reset.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset && (state_r == ST_SEND) && (grant_id_r == IDW'(i))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  assign tx_start    = tx_start_r;
  assign tx_data     = tx_data_r;
  assign grant_valid = grant_valid_r;
  assign grant_id    = grant_id_r;

endmodule
